// File: rtl/step_dir_gen.sv
// -----------------------------------------------------------------------------
// step_dir_gen
//
// Turns queued move commands (direction, step count, step period) into the
// step/dir pulse train for a microstep driver. A one-deep command buffer lets
// a second move wait while the first runs, so consecutive moves execute with
// only a single LOAD cycle between them.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   move_valid   command valid
//   move_ready   command buffer empty, command can be accepted
//   move_dir     1 = forward, 0 = reverse
//   move_steps   number of steps in the move
//   move_period  clk cycles between step rising edges
//   abort        synchronous stop request
//   step         step pulse to driver
//   dir          direction to driver
//   busy         engine executing a move or a command is pending
//   move_done    one-cycle pulse on move completion
//   position     signed step position
//
// Optional feature:
//   STEP_DIR_GEN_POSITION_EN - when defined, a 32-bit signed position counter
//   tracks every launched step (+1 forward, -1 reverse, two's complement
//   wrap). When undefined the counter is removed and position is tied to 0.
//
// Timing note: step, dir and move_done are registered from the current
// state, so the pins trail the state register by one clock. This gives the
// accept-to-first-step latency of three edges and makes the dir-to-step
// setup time exactly dir_setup_clks cycles at the pins.
// -----------------------------------------------------------------------------
module step_dir_gen #(
  parameter int steps_bits     = 32,
  parameter int period_bits    = 32,
  parameter int pulse_clks     = 16,
  parameter int dir_setup_clks = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   move_valid,
  output logic                   move_ready,
  input  logic                   move_dir,
  input  logic [steps_bits-1:0]  move_steps,
  input  logic [period_bits-1:0] move_period,
  input  logic                   abort,
  output logic                   step,
  output logic                   dir,
  output logic                   busy,
  output logic                   move_done,
  output logic [31:0]            position
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    DIR_SETUP = 3'd2,
    STEP_HIGH = 3'd3,
    STEP_LOW  = 3'd4
  } state_t;

  localparam logic [period_bits-1:0] PULSE_LEN  = period_bits'(pulse_clks);
  localparam logic [period_bits-1:0] MIN_PERIOD = period_bits'(pulse_clks + pulse_clks);
  localparam logic [period_bits-1:0] SETUP_LEN  = period_bits'(dir_setup_clks);
  localparam logic [period_bits-1:0] TIMER_ONE  = period_bits'(1'b1);
  localparam logic [period_bits-1:0] TIMER_ZERO = {period_bits{1'b0}};
  localparam logic [steps_bits-1:0]  STEPS_ONE  = steps_bits'(1'b1);
  localparam logic [steps_bits-1:0]  STEPS_ZERO = {steps_bits{1'b0}};

  // Engine state
  state_t                 state_r;
  logic [period_bits-1:0] timer_r;       // cycles left in current phase, minus one
  logic [steps_bits-1:0]  remaining_r;   // steps still to launch, including current
  logic [period_bits-1:0] low_len_r;     // STEP_LOW length of the active move
  logic                   cmd_dir_r;     // direction requested by the active move
  logic                   dir_r;         // direction currently applied
  logic                   aborting_r;    // finish this pulse, then stop

  // Command buffer
  logic                   pend_valid_r;
  logic                   pend_dir_r;
  logic [steps_bits-1:0]  pend_steps_r;
  logic [period_bits-1:0] pend_period_r;

  // Decode
  state_t                 state_nx_s;
  logic                   take_s;        // buffered command moves to the engine
  logic                   done_s;        // move completes on this edge
  logic                   accept_s;
  logic                   pend_nx_s;
  logic [period_bits-1:0] pend_eff_s;    // buffered period clamped to 2*pulse_clks

  // Next-state decode, buffer hand-off, acceptance and period clamp
  always_comb begin
    state_nx_s = state_r;
    take_s     = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_valid_r && !abort) begin
          state_nx_s = LOAD;
          take_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (remaining_r == STEPS_ZERO) begin
          // Empty move: report completion without touching dir
          done_s = 1'b1;
          if (pend_valid_r) begin
            state_nx_s = LOAD;
            take_s     = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end else if (cmd_dir_r != dir_r) begin
          state_nx_s = DIR_SETUP;
        end else begin
          state_nx_s = STEP_HIGH;
        end
      end
      DIR_SETUP: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (timer_r == TIMER_ZERO) begin
          state_nx_s = STEP_HIGH;
        end else begin
          state_nx_s = DIR_SETUP;
        end
      end
      STEP_HIGH: begin
        // abort never truncates a pulse; it is honoured when the pulse ends
        if (timer_r == TIMER_ZERO) begin
          if (abort || aborting_r) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = STEP_LOW;
          end
        end else begin
          state_nx_s = STEP_HIGH;
        end
      end
      STEP_LOW: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (timer_r == TIMER_ZERO) begin
          if (remaining_r > STEPS_ONE) begin
            state_nx_s = STEP_HIGH;
          end else begin
            done_s = 1'b1;
            if (pend_valid_r) begin
              state_nx_s = LOAD;
              take_s     = 1'b1;
            end else begin
              state_nx_s = IDLE;
            end
          end
        end else begin
          state_nx_s = STEP_LOW;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // abort wins over a simultaneous accept
    accept_s = move_valid & ~pend_valid_r & ~abort;

    if (abort) begin
      pend_nx_s = 1'b0;
    end else if (take_s) begin
      pend_nx_s = 1'b0;
    end else if (accept_s) begin
      pend_nx_s = 1'b1;
    end else begin
      pend_nx_s = pend_valid_r;
    end

    if (pend_period_r < MIN_PERIOD) begin
      pend_eff_s = MIN_PERIOD;
    end else begin
      pend_eff_s = pend_period_r;
    end
  end

  // Engine state, command buffer and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= IDLE;
      timer_r       <= TIMER_ZERO;
      remaining_r   <= STEPS_ZERO;
      low_len_r     <= TIMER_ZERO;
      cmd_dir_r     <= 1'b1;
      dir_r         <= 1'b1;
      aborting_r    <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_dir_r    <= 1'b1;
      pend_steps_r  <= STEPS_ZERO;
      pend_period_r <= TIMER_ZERO;
      step          <= 1'b0;
      dir           <= 1'b1;
      busy          <= 1'b0;
      move_done     <= 1'b0;
      move_ready    <= 1'b1;
    end else begin
      state_r      <= state_nx_s;
      pend_valid_r <= pend_nx_s;

      if (accept_s) begin
        pend_dir_r    <= move_dir;
        pend_steps_r  <= move_steps;
        pend_period_r <= move_period;
      end

      if (take_s) begin
        cmd_dir_r   <= pend_dir_r;
        remaining_r <= pend_steps_r;
        low_len_r   <= pend_eff_s - PULSE_LEN;
      end else if ((state_r == STEP_LOW) && (state_nx_s == STEP_HIGH)) begin
        remaining_r <= remaining_r - STEPS_ONE;
      end

      // dir only ever moves on the LOAD exit, when step is guaranteed low
      if ((state_r == LOAD) && (state_nx_s == DIR_SETUP)) begin
        dir_r <= cmd_dir_r;
      end

      // Phase timer reloads on every state change, else counts down to zero
      if (state_nx_s != state_r) begin
        case (state_nx_s)
          DIR_SETUP: timer_r <= SETUP_LEN - TIMER_ONE;
          STEP_HIGH: timer_r <= PULSE_LEN - TIMER_ONE;
          STEP_LOW:  timer_r <= low_len_r - TIMER_ONE;
          default:   timer_r <= TIMER_ZERO;
        endcase
      end else if (timer_r != TIMER_ZERO) begin
        timer_r <= timer_r - TIMER_ONE;
      end

      if (state_nx_s == IDLE) begin
        aborting_r <= 1'b0;
      end else if (abort && (state_r == STEP_HIGH)) begin
        aborting_r <= 1'b1;
      end

      step       <= (state_r == STEP_HIGH);
      dir        <= dir_r;
      move_done  <= done_s;
      busy       <= (state_nx_s != IDLE) | pend_nx_s;
      move_ready <= ~pend_nx_s;
    end
  end

`ifdef STEP_DIR_GEN_POSITION_EN
  // Position counts each pulse on the edge its step pin rises
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      position <= 32'd0;
    end else if ((state_r == STEP_HIGH) && (timer_r == (PULSE_LEN - TIMER_ONE))) begin
      if (dir_r) begin
        position <= position + 32'd1;
      end else begin
        position <= position - 32'd1;
      end
    end
  end
`else
  assign position = 32'd0;
`endif

endmodule

// File: tb/tb_step_dir_gen.sv
// -----------------------------------------------------------------------------
// tb_step_dir_gen
//
// Self-checking bench for step_dir_gen. A negedge monitor records the edge
// index of every step rise/fall, move_done sample and dir change. A timing
// model derived from the move rules (accept edge, load edge, setup delay,
// effective period) predicts the same event lists, which are scored per test.
// -----------------------------------------------------------------------------
module tb_step_dir_gen;

  localparam int PULSE = 16;
  localparam int SETUP = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        move_valid = 1'b0;
  logic        move_dir = 1'b1;
  logic [31:0] move_steps = 32'd0;
  logic [31:0] move_period = 32'd0;
  logic        abort = 1'b0;
  logic        move_ready;
  logic        step;
  logic        dir;
  logic        busy;
  logic        move_done;
  logic [31:0] position;

  always #5 clk = ~clk;

  step_dir_gen dut (
    .clk         (clk),
    .resetn      (resetn),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_dir    (move_dir),
    .move_steps  (move_steps),
    .move_period (move_period),
    .abort       (abort),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .move_done   (move_done),
    .position    (position)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, labelled with the index of the edge that produced them
  int   rise_q[$];
  int   rdir_q[$];
  int   fall_q[$];
  int   done_q[$];
  int   dchg_q[$];
  logic prev_step = 1'b0;
  logic prev_dir  = 1'b1;

  always @(negedge clk) begin
    if (step === 1'b1 && prev_step === 1'b0) begin
      rise_q.push_back(cyc);
      rdir_q.push_back(int'(dir));
    end
    if (step === 1'b0 && prev_step === 1'b1) fall_q.push_back(cyc);
    if (move_done === 1'b1) done_q.push_back(cyc);
    if (dir !== prev_dir) dchg_q.push_back(cyc);
    prev_step = step;
    prev_dir  = dir;
  end

  // Reference model state and predictions
  int m_dir  = 1;
  int m_pos  = 0;
  int m_free = 0;
  int ex_rise[$];
  int ex_rdir[$];
  int ex_done[$];
  int ex_dchg[$];
  int cmd_acc[$];
  int cmd_dir[$];
  int cmd_steps[$];
  int cmd_per[$];

  function automatic int exp_pos();
`ifdef STEP_DIR_GEN_POSITION_EN
    return m_pos;
`else
    return 0;
`endif
  endfunction

  task automatic clear_all();
    rise_q.delete(); rdir_q.delete(); fall_q.delete(); done_q.delete(); dchg_q.delete();
    ex_rise.delete(); ex_rdir.delete(); ex_done.delete(); ex_dchg.delete();
    cmd_acc.delete(); cmd_dir.delete(); cmd_steps.delete(); cmd_per.delete();
  endtask

  // Called at a negedge; presents a command until it is accepted
  task automatic send(input int d, input int s, input int p);
    int n;
    n = 0;
    while (move_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      vectors++;
      errors++;
      $display("FAIL send_ready: move_ready=%b required 1 within 5000 cycles", move_ready);
    end
    move_valid  = 1'b1;
    move_dir    = d[0];
    move_steps  = 32'(s);
    move_period = 32'(p);
    cmd_acc.push_back(cyc + 1);
    cmd_dir.push_back(d);
    cmd_steps.push_back(s);
    cmd_per.push_back(p);
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 20000);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0 after %0d cycles", busy, n);
    end
    repeat (4) @(negedge clk);
  endtask

  // Predict event edges from the queued commands
  task automatic run_model();
    int l, s, eff, r0;
    foreach (cmd_acc[i]) begin
      l = (cmd_acc[i] + 1 > m_free) ? cmd_acc[i] + 1 : m_free;
      if (cmd_steps[i] == 0) begin
        ex_done.push_back(l + 1);
        m_free = l + 1;
      end else begin
        s = (cmd_dir[i] != m_dir) ? SETUP : 0;
        if (s != 0) ex_dchg.push_back(l + 2);
        m_dir = cmd_dir[i];
        eff = (cmd_per[i] < 2 * PULSE) ? 2 * PULSE : cmd_per[i];
        r0 = l + 2 + s;
        for (int k = 0; k < cmd_steps[i]; k++) begin
          ex_rise.push_back(r0 + k * eff);
          ex_rdir.push_back(cmd_dir[i]);
        end
        m_free = r0 + cmd_steps[i] * eff - 1;
        ex_done.push_back(m_free);
        m_pos += (m_dir != 0) ? cmd_steps[i] : -cmd_steps[i];
      end
    end
  endtask

  // Scoreboard drain: observed events against model predictions
  task automatic score(input string name);
    vectors++;
    if (rise_q.size() != ex_rise.size()) begin
      errors++;
      $display("FAIL %s rise_count: got %0d required %0d", name, rise_q.size(), ex_rise.size());
    end else begin
      foreach (ex_rise[i]) begin
        vectors++;
        if (rise_q[i] != ex_rise[i]) begin
          errors++;
          $display("FAIL %s rise_edge[%0d]: got %0d required %0d", name, i, rise_q[i], ex_rise[i]);
        end
        vectors++;
        if (rdir_q[i] != ex_rdir[i]) begin
          errors++;
          $display("FAIL %s rise_dir[%0d]: got %0d required %0d", name, i, rdir_q[i], ex_rdir[i]);
        end
      end
    end
    vectors++;
    if (fall_q.size() != rise_q.size()) begin
      errors++;
      $display("FAIL %s fall_count: got %0d required %0d", name, fall_q.size(), rise_q.size());
    end else begin
      foreach (fall_q[i]) begin
        vectors++;
        if (fall_q[i] - rise_q[i] != PULSE) begin
          errors++;
          $display("FAIL %s pulse_width[%0d]: got %0d required %0d", name, i, fall_q[i] - rise_q[i], PULSE);
        end
      end
    end
    vectors++;
    if (done_q.size() != ex_done.size()) begin
      errors++;
      $display("FAIL %s done_count: got %0d required %0d", name, done_q.size(), ex_done.size());
    end else begin
      foreach (ex_done[i]) begin
        vectors++;
        if (done_q[i] != ex_done[i]) begin
          errors++;
          $display("FAIL %s done_edge[%0d]: got %0d required %0d", name, i, done_q[i], ex_done[i]);
        end
      end
    end
    vectors++;
    if (dchg_q.size() != ex_dchg.size()) begin
      errors++;
      $display("FAIL %s dir_change_count: got %0d required %0d", name, dchg_q.size(), ex_dchg.size());
    end else begin
      foreach (ex_dchg[i]) begin
        vectors++;
        if (dchg_q[i] != ex_dchg[i]) begin
          errors++;
          $display("FAIL %s dir_change_edge[%0d]: got %0d required %0d", name, i, dchg_q[i], ex_dchg[i]);
        end
      end
    end
    vectors++;
    if (position !== 32'(exp_pos())) begin
      errors++;
      $display("FAIL %s position: got %0d required %0d", name, $signed(position), exp_pos());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (step !== 1'b0)       begin errors++; $display("FAIL reset_step: got %b required 0", step); end
    if (dir !== 1'b1)        begin errors++; $display("FAIL reset_dir: got %b required 1", dir); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (move_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b required 0", move_done); end
    if (move_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", move_ready); end
    if (position !== 32'd0)  begin errors++; $display("FAIL reset_position: got %0d required 0", position); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (move_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b busy=%b required ready=1 busy=0", move_ready, busy);
    end
    clear_all();
  endtask

  task automatic test_basic();
    clear_all();
    send(1, 3, 40);
    wait_idle();
    run_model();
    score("basic");
  endtask

  task automatic test_dir_change();
    clear_all();
    send(0, 4, 50);
    wait_idle();
    run_model();
    score("dir_change");
    if (rise_q.size() > 0 && dchg_q.size() > 0) begin
      vectors++;
      if (rise_q[0] - dchg_q[0] != SETUP) begin
        errors++;
        $display("FAIL dir_setup_gap: got %0d required %0d", rise_q[0] - dchg_q[0], SETUP);
      end
    end
  endtask

  task automatic test_clamp();
    clear_all();
    send(0, 2, 10);
    wait_idle();
    run_model();
    score("clamp");
    if (rise_q.size() > 1) begin
      vectors++;
      if (rise_q[1] - rise_q[0] != 2 * PULSE) begin
        errors++;
        $display("FAIL clamp_spacing: got %0d required %0d", rise_q[1] - rise_q[0], 2 * PULSE);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    send(1, 5, 40);
    send(1, 2, 40);
    vectors++;
    if (move_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_pending: got %b required 0", move_ready);
    end
    wait_idle();
    run_model();
    score("back_to_back");
    if (rise_q.size() > 5) begin
      vectors++;
      if (rise_q[5] - rise_q[4] != 41) begin
        errors++;
        $display("FAIL b2b_boundary: got %0d required 41", rise_q[5] - rise_q[4]);
      end
    end
  endtask

  task automatic test_zero_steps();
    clear_all();
    send(0, 0, 40);
    wait_idle();
    run_model();
    score("zero_steps");
    vectors++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL zero_dir_kept: got %b required 1", dir);
    end
  endtask

  task automatic test_abort();
    int n;
    clear_all();
    send(1, 10, 40);
    send(1, 3, 40);
    n = 0;
    while (rise_q.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    repeat (100) @(negedge clk);
    m_pos += 2;
    m_dir  = 1;
    m_free = 0;
    vectors += 6;
    if (rise_q.size() != 2) begin errors++; $display("FAIL abort_rises: got %0d required 2", rise_q.size()); end
    if (fall_q.size() != 2) begin errors++; $display("FAIL abort_falls: got %0d required 2", fall_q.size()); end
    else if (fall_q[1] - rise_q[1] != PULSE) begin
      errors++;
      $display("FAIL abort_pulse_width: got %0d required %0d", fall_q[1] - rise_q[1], PULSE);
    end
    if (done_q.size() != 0) begin errors++; $display("FAIL abort_no_done: got %0d required 0", done_q.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (move_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", move_ready); end
    if (position !== 32'(exp_pos())) begin
      errors++;
      $display("FAIL abort_position: got %0d required %0d", $signed(position), exp_pos());
    end
    // abort together with a valid command drops the command
    abort       = 1'b1;
    move_valid  = 1'b1;
    move_dir    = 1'b1;
    move_steps  = 32'd3;
    move_period = 32'd40;
    @(negedge clk);
    abort      = 1'b0;
    move_valid = 1'b0;
    vectors += 2;
    if (move_ready !== 1'b1) begin errors++; $display("FAIL abort_prio_ready: got %b required 1", move_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_prio_busy: got %b required 0", busy); end
    repeat (60) @(negedge clk);
    vectors++;
    if (rise_q.size() != 2) begin
      errors++;
      $display("FAIL abort_prio_rises: got %0d required 2", rise_q.size());
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 70)));
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    wait_idle();
    run_model();
    score("random");
  endtask

  task automatic test_reset_midpulse();
    int n;
    clear_all();
    send(0, 3, 40);
    n = 0;
    while (rise_q.size() < 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2 resetn = 1'b0;
    #1;
    vectors += 5;
    if (step !== 1'b0)       begin errors++; $display("FAIL midreset_step: got %b required 0", step); end
    if (position !== 32'd0)  begin errors++; $display("FAIL midreset_position: got %0d required 0", position); end
    if (dir !== 1'b1)        begin errors++; $display("FAIL midreset_dir: got %b required 1", dir); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    if (move_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", move_ready); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    m_dir  = 1;
    m_pos  = 0;
    m_free = 0;
    clear_all();
    send(1, 1, 40);
    wait_idle();
    run_model();
    score("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dir_change();
    test_clamp();
    test_back_to_back();
    test_zero_steps();
    test_abort();
    test_random();
    test_reset_midpulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
Upstream motion stage that turns queued move commands into step/dir pulse trains. Each command carries a direction, a step count and a step period. Output drives the step/dir/enable inputs of the dual H-bridge microstep driver. A one-deep command buffer lets back-to-back moves run without gaps.

Parameters:
steps_bits, 32, width of move step count
period_bits, 32, width of step period in clk cycles
pulse_clks, 16, step high time in clk cycles (≥1)
dir_setup_clks, 8, clk cycles dir must be stable before a step rising edge (≥1)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
move_valid  input  1  command valid
move_ready  output  1  command buffer empty, can accept
move_dir  input  1  1 = forward (phase increment), 0 = reverse
move_steps  input  steps_bits  number of steps in move
move_period  input  period_bits  clk cycles between step rising edges
abort  input  1  synchronous stop request
step  output  1  step pulse to driver
dir  output  1  direction to driver
busy  output  1  engine executing a move or command pending
move_done  output  1  one-cycle pulse on move completion
position  output  32  signed step position (see Optional Feature)

Behaviour:
- Reset (async, resetn low): step=0, dir=1, busy=0, move_done=0, move_ready=1, position=0, buffer empty, FSM IDLE.
- Handshake: accept when move_valid & move_ready on a clk edge; command latched into pending register; move_ready=!pending. Inputs ignored when not accepted.
- FSM states: IDLE, LOAD, DIR_SETUP, STEP_HIGH, STEP_LOW.
- IDLE: if pending → LOAD (pending moved to active, buffer freed same edge).
- LOAD: steps==0 → pulse move_done, → IDLE (or LOAD if another pending); dir unchanged. move_dir!=dir → dir<=move_dir, → DIR_SETUP. Else → STEP_HIGH.
- DIR_SETUP: hold dir_setup_clks cycles, → STEP_HIGH.
- STEP_HIGH: step=1 for exactly pulse_clks cycles; position updated (+1 if dir, −1 otherwise) on the rising edge cycle; → STEP_LOW.
- STEP_LOW: step=0 for eff_period − pulse_clks cycles, eff_period = max(move_period, 2*pulse_clks). Remaining steps decrement per step. If remaining>0 → STEP_HIGH; else move_done pulse on last STEP_LOW cycle, → LOAD if pending else IDLE.
- Latency: accept on edge N with engine idle, same dir → step rises on edge N+3 (IDLE→LOAD→STEP_HIGH). Back-to-back same-dir moves: step spacing across boundary = eff_period + 1 cycles (LOAD cycle).
- Dir changes only in LOAD, never while step=1; dir stable ≥ dir_setup_clks before any rising edge and throughout the pulse.
- abort: pending cleared same edge; if STEP_HIGH, pulse completes full pulse_clks (no runt) then IDLE; any other state → IDLE next edge. No move_done on abort. abort has priority over a simultaneous accept (command dropped, move_ready stays high).
- busy = (state!=IDLE) | pending.
- Counters saturate-free: steps up to 2^steps_bits−1; position wraps two's complement.

Optional Feature:
STEP_DIR_GEN_POSITION_EN — defined: 32-bit signed position counter implemented as above. Undefined: counter removed, position tied to 0.

Test Plan:
- Reset then move dir=1, steps=3, period=40 → 3 step pulses, each high 16 cycles, rising edges 40 apart, first at accept+3; move_done single pulse; position=3.
- dir=0 move after dir=1 idle → dir falls in LOAD, first step rises 8 cycles later; position decrements by steps.
- period=10 (below 2*pulse_clks) → period clamped to 32 cycles.
- Two moves queued back-to-back same dir (5 then 2 steps) → move_ready low while second pending, 7 total pulses, boundary spacing eff_period+1, two move_done pulses.
- abort asserted mid STEP_HIGH of step 2 of 10 with pending move → pulse finishes full 16 cycles, no further steps, pending dropped, busy=0, no move_done.
- steps=0 command → no step, dir unchanged, move_done pulse one cycle after LOAD entry; resetn low mid-pulse → step=0 immediately, position=0.
